// File: rtl/uart_tx_fifo_if.sv
// Host-write / transmitter-launch bundle for the UART transmit FIFO.
// The master side is the host plus transmitter; the slave side is the FIFO itself.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             flush;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             start;
  logic [WIDTH-1:0] tx_data_out;
  logic             tx_active;
  logic             done_tx;

  modport master (
    output wr_en, wr_data, flush, tx_active, done_tx,
    input  full, empty, count, overflow, start, tx_data_out
  );

  modport slave (
    input  wr_en, wr_data, flush, tx_active, done_tx,
    output full, empty, count, overflow, start, tx_data_out
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte queue feeding a UART transmitter: pops the head byte and
// issues a one-cycle start pulse, then waits for the end-of-frame pulse.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             overflow_reg;
  logic [WIDTH-1:0] tx_data_reg;

  logic full, empty, push, pop, start;

  assign full  = (count_reg == DEPTH_CNT);
  assign empty = (count_reg == '0);

  // Flush outranks a concurrent write; a full queue rejects even if a pop lands this cycle.
  assign push = bus.wr_en && !full && !bus.flush;

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    start      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty && !bus.tx_active && !bus.flush) begin
          pop        = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        start      = 1'b1;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.done_tx) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Storage array carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (bus.flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Registered read of the head entry; holds until the next pop, so flush leaves it intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data_reg <= '0;
    end else if (pop) begin
      tx_data_reg <= mem[rd_ptr_reg];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else if (bus.wr_en && full && !bus.flush) begin
      overflow_reg <= 1'b1;
    end
  end

  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.count       = count_reg;
  assign bus.overflow    = overflow_reg;
  assign bus.start       = start;
  assign bus.tx_data_out = tx_data_reg;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed checks of uart_tx_fifo: latency, ordering, fill/overflow, wrap,
// flush mid-frame and asynchronous reset mid-frame.
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   start_cnt = 0;

  uart_tx_fifo_if #(.DEPTH(16), .WIDTH(8)) bus ();

  uart_tx_fifo #(.DEPTH(16), .WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.start === 1'b1) start_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    bus.done_tx = 1'b1;
    tick();
    bus.done_tx = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int max, output int waited);
    waited = 0;
    while (bus.start !== 1'b1 && waited < max) begin
      tick();
      waited++;
    end
    check(tag, 32'(bus.start), 32'd1);
  endtask

  task automatic write_byte(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  initial begin
    int w;
    int base;
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.flush = 1'b0;
    bus.tx_active = 1'b0; bus.done_tx = 1'b0;
    repeat (3) tick();
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_start", 32'(bus.start), 32'd0);
    check("rst_data", 32'(bus.tx_data_out), 32'd0);
    rst = 1'b0;
    tick();

    // Single byte: written in cycle k, start in k+2 only
    write_byte(8'hA5);
    check("single_k1_start", 32'(bus.start), 32'd0);
    check("single_k1_count", 32'(bus.count), 32'd1);
    tick();
    check("single_k2_start", 32'(bus.start), 32'd1);
    check("single_k2_data", 32'(bus.tx_data_out), 32'hA5);
    check("single_k2_empty", 32'(bus.empty), 32'd1);
    bus.done_tx = 1'b1;   // must be ignored while launching
    tick();
    bus.done_tx = 1'b0;
    check("single_k3_start", 32'(bus.start), 32'd0);
    write_byte(8'h3C);
    repeat (4) tick();
    check("done_in_launch_ignored", 32'(bus.count), 32'd1);
    check("done_in_launch_start", 32'(start_cnt), 32'd1);
    pulse_done();
    wait_start("b2b_3c_start", 10, w);
    check("b2b_3c_latency", 32'(w), 32'd1);
    check("b2b_3c_data", 32'(bus.tx_data_out), 32'h3C);
    tick();
    pulse_done();
    tick();

    // Ordering of three back-to-back bytes
    base = start_cnt;
    write_byte(8'h01);
    write_byte(8'h02);
    write_byte(8'h03);
    check("order_data0", 32'(bus.tx_data_out), 32'h01);
    for (int i = 1; i < 3; i++) begin
      pulse_done();
      wait_start($sformatf("order_start%0d", i), 10, w);
      check($sformatf("order_latency%0d", i), 32'(w), 32'd1);
      check($sformatf("order_data%0d", i), 32'(bus.tx_data_out), 32'(i + 1));
      tick();
    end
    pulse_done();
    repeat (5) tick();
    check("order_pulses", 32'(start_cnt - base), 32'd3);

    // Fill to DEPTH with the transmitter busy, then overflow
    bus.tx_active = 1'b1;
    for (int i = 0; i < 16; i++) write_byte(8'(8'h10 + i));
    check("fill_full", 32'(bus.full), 32'd1);
    check("fill_count", 32'(bus.count), 32'd16);
    check("fill_overflow_clear", 32'(bus.overflow), 32'd0);
    write_byte(8'hEE);
    check("ovf_count", 32'(bus.count), 32'd16);
    check("ovf_flag", 32'(bus.overflow), 32'd1);
    check("ovf_full", 32'(bus.full), 32'd1);
    // Write while full in the same cycle as a pop: still dropped
    bus.wr_en = 1'b1; bus.wr_data = 8'hEF; bus.tx_active = 1'b0;
    tick();
    bus.wr_en = 1'b0;
    check("full_pop_drop_count", 32'(bus.count), 32'd15);
    check("full_pop_start", 32'(bus.start), 32'd1);
    check("full_pop_data", 32'(bus.tx_data_out), 32'h10);
    tick();
    pulse_done();
    for (int i = 1; i < 16; i++) begin
      wait_start($sformatf("drain_start%0d", i), 10, w);
      check($sformatf("drain_data%0d", i), 32'(bus.tx_data_out), 32'(8'h10 + i));
      tick();
      pulse_done();
    end
    check("drain_empty", 32'(bus.empty), 32'd1);
    check("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Wrap: 40 bytes through the pointers with random end-of-frame delays
    fork
      begin
        int i = 0;
        int guard = 0;
        while (i < 40 && guard < 5000) begin
          if (!bus.full) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 8'(i);
            i++;
          end else begin
            bus.wr_en = 1'b0;
          end
          tick();
          guard++;
        end
        bus.wr_en = 1'b0;
        check("wrap_writer_done", 32'(i), 32'd40);
      end
      begin
        int ws;
        for (int j = 0; j < 40; j++) begin
          wait_start($sformatf("wrap_start%0d", j), 50, ws);
          check($sformatf("wrap_data%0d", j), 32'(bus.tx_data_out), 32'(j));
          tick();
          repeat ($urandom_range(0, 4)) tick();
          pulse_done();
        end
      end
    join
    tick();
    check("wrap_empty", 32'(bus.empty), 32'd1);
    check("wrap_count", 32'(bus.count), 32'd0);

    // Flush while byte 0 is in flight; a simultaneous write is discarded
    base = start_cnt;
    for (int i = 0; i < 5; i++) write_byte(8'(8'h50 + i));
    check("flush_pre_count", 32'(bus.count), 32'd4);
    bus.flush = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'h99;
    tick();
    bus.flush = 1'b0; bus.wr_en = 1'b0;
    check("flush_count", 32'(bus.count), 32'd0);
    check("flush_empty", 32'(bus.empty), 32'd1);
    check("flush_data_held", 32'(bus.tx_data_out), 32'h50);
    pulse_done();
    repeat (6) tick();
    check("flush_no_start", 32'(start_cnt - base), 32'd1);
    check("flush_data_after", 32'(bus.tx_data_out), 32'h50);
    check("flush_ovf_kept", 32'(bus.overflow), 32'd1);

    // Asynchronous reset between edges while waiting for end of frame
    for (int i = 0; i < 4; i++) write_byte(8'(8'h60 + i));
    check("arst_pre_count", 32'(bus.count), 32'd3);
    #2;
    rst = 1'b1;
    base = start_cnt;
    #1;
    check("arst_count", 32'(bus.count), 32'd0);
    check("arst_empty", 32'(bus.empty), 32'd1);
    check("arst_data", 32'(bus.tx_data_out), 32'd0);
    check("arst_overflow", 32'(bus.overflow), 32'd0);
    check("arst_start", 32'(bus.start), 32'd0);
    tick();
    #2;
    rst = 1'b0;
    repeat (10) tick();
    check("arst_no_start", 32'(start_cnt - base), 32'd0);
    write_byte(8'h77);
    wait_start("post_rst_start", 10, w);
    check("post_rst_latency", 32'(w), 32'd1);
    check("post_rst_data", 32'(bus.tx_data_out), 32'h77);
    tick();
    pulse_done();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL provide parameter DEPTH, default 16, FIFO entry count (power of two, 4..256).
REQ-002 SHALL provide parameter WIDTH, default 8, data bits per entry.
REQ-003 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL provide port wr_en  input  1  host write strobe, one byte per cycle high.
REQ-006 SHALL provide port wr_data  input  WIDTH  host byte to enqueue.
REQ-007 SHALL provide port flush  input  1  synchronous clear of queued (not in-flight) bytes.
REQ-008 SHALL provide port full  output  1  high when count equals DEPTH.
REQ-009 SHALL provide port empty  output  1  high when count equals 0.
REQ-010 SHALL provide port count  output  log2(DEPTH)+1  number of queued bytes.
REQ-011 SHALL provide port overflow  output  1  sticky flag, write attempted while full.
REQ-012 SHALL provide port start  output  1  one-cycle launch pulse to transmitter.
REQ-013 SHALL provide port tx_data_out  output  WIDTH  byte presented to transmitter.
REQ-014 SHALL provide port tx_active  input  1  transmitter busy indication.
REQ-015 SHALL provide port done_tx  input  1  transmitter end-of-frame pulse.

Function
REQ-016 SHALL store bytes in circular buffer with read/write pointers wrapping DEPTH-1 -> 0.
REQ-017 SHALL accept write when wr_en=1 and full=0; byte stored at edge, count+1.
REQ-018 SHALL drop write when wr_en=1 and full=1, leave contents unchanged, set overflow at same edge.
REQ-019 SHALL, when full and a pop occurs in the same cycle, still drop the write (full evaluated pre-edge).
REQ-020 SHALL, on simultaneous accepted write and pop, leave count unchanged and advance both pointers.
REQ-021 SHALL implement FSM states IDLE, LAUNCH, WAIT_DONE.
REQ-022 IDLE: if empty=0 and tx_active=0 and flush=0 -> LAUNCH; head byte loaded into tx_data_out, read pointer advanced, count-1 at that edge.
REQ-023 LAUNCH: start=1 for exactly this one cycle; unconditional -> WAIT_DONE.
REQ-024 WAIT_DONE: start=0; on done_tx=1 -> IDLE; otherwise remain.
REQ-025 SHALL hold tx_data_out stable from LAUNCH entry until next pop.
REQ-026 SHALL achieve latency: byte written into empty FIFO in cycle k with FSM IDLE -> start high in cycle k+2.
REQ-027 SHALL achieve back-to-back: done_tx in cycle m with non-empty FIFO -> start high in cycle m+2.
REQ-028 flush=1: SHALL zero pointers and count at edge, not clear overflow bit; SHALL NOT alter FSM state or tx_data_out (in-flight byte completes).
REQ-029 flush with simultaneous wr_en: flush wins, write discarded, overflow unaffected.
REQ-030 SHALL clear overflow only by reset.
REQ-031 SHALL ignore done_tx in IDLE and LAUNCH.
REQ-032 full, empty, count SHALL be registered-state-derived, valid every cycle.

Reset
REQ-033 rst=1 SHALL immediately force: FSM IDLE, pointers 0, count 0, empty=1, full=0, overflow=0, start=0, tx_data_out=0.
REQ-034 SHALL resume operation on first rising clk edge after rst deassertion; reset mid-frame discards in-flight and queued bytes.

Verification
REQ-035 Single byte: write 0xA5 cycle k into empty FIFO -> start=1 cycle k+2 only, tx_data_out=0xA5, empty=1 from k+2.
REQ-036 Ordering: write 0x01,0x02,0x03 back-to-back, pulse done_tx after each start -> tx_data_out sequence 0x01,0x02,0x03, start exactly 3 pulses.
REQ-037 Fill/overflow: hold tx_active=1, write 17 bytes (DEPTH=16) -> full=1 after 16th, 17th dropped, overflow=1, count=16.
REQ-038 Wrap: push/pop 40 bytes 0x00..0x27 with random done_tx delays -> all bytes delivered in order, no loss across pointer wrap.
REQ-039 Flush mid-frame: 5 bytes queued, byte 0 in WAIT_DONE, flush=1 -> count=0, tx_data_out unchanged, done_tx returns FSM to IDLE, no further start.
REQ-040 Async reset: assert rst between clock edges during WAIT_DONE with count=3 -> outputs at reset values before next edge, start never pulses afterward without new writes.
